// File: rtl/dstack_spill_control_pkg.sv
// Shared types for the data-stack spill/fill controller: FSM states and
// instruction stack-movement encodings.
package dstack_spill_control_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSpill,
    StFill
  } spill_state_e;

  typedef enum logic [1:0] {
    MvNone  = 2'b00,
    MvPush1 = 2'b01,
    MvPop1  = 2'b10,
    MvPop2  = 2'b11
  } movement_e;

endpackage

// File: rtl/dstack_spill_control.sv
// Data-stack cache spill/fill controller: keeps the cached entry count between the watermarks.
// Optional: define DSTACK_UNDERFLOW_TRAP_EN to pulse `underflow` instead of saturating at zero.
module dstack_spill_control
  import dstack_spill_control_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned HIGH_WATER = 12,
  parameter int unsigned LOW_WATER  = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     issue,
  input  logic [1:0]               movement,
  output logic                     stall,
  input  logic [ADDR_WIDTH-1:0]    stack_base,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH)-1:0] bottom_idx,
  output logic                     fill_we,
`ifdef DSTACK_UNDERFLOW_TRAP_EN
  output logic                     underflow,
`endif
  output logic [$clog2(DEPTH):0]   cached_count,
  output logic [ADDR_WIDTH-1:0]    spilled_count
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;
  localparam int unsigned SumW = CntW + 2;
  localparam logic [ADDR_WIDTH-1:0] Stride = ADDR_WIDTH'(WORD_WIDTH / 8);
  localparam logic [CntW-1:0] Full  = CntW'(DEPTH);
  localparam logic [CntW-1:0] HighW = CntW'(HIGH_WATER);
  localparam logic [CntW-1:0] LowW  = CntW'(LOW_WATER);

  spill_state_e          state_q, state_d;
  logic [IdxW-1:0]       bottom_q, bottom_d;
  logic [CntW-1:0]       cached_q, cached_d;
  logic [ADDR_WIDTH-1:0] spilled_q, spilled_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;

  logic            is_push, starved, underrun, retire, apply_pop, spill_ack, fill_ack;
  logic [CntW-1:0] pop_need;
  logic [SumW-1:0] cnt_sum;  // top bit acts as a borrow flag for the clamp at zero

  always_comb begin
    is_push = (movement == MvPush1);
    unique case (movement_e'(movement))
      MvPop1:  pop_need = CntW'(1);
      MvPop2:  pop_need = CntW'(2);
      default: pop_need = '0;
    endcase

    starved  = (pop_need > cached_q);
    stall    = issue && ((is_push && cached_q == Full) || (starved && spilled_q != '0));
    underrun = issue && starved && (spilled_q == '0);
    retire   = issue && !stall;
`ifdef DSTACK_UNDERFLOW_TRAP_EN
    apply_pop = retire && !underrun;
`else
    apply_pop = retire;
`endif
    spill_ack = (state_q == StSpill) && mem_ack;
    fill_ack  = (state_q == StFill) && mem_ack;

    // Core movement and memory completion both land in the same cycle.
    cnt_sum  = SumW'(cached_q) + SumW'(retire && is_push) + SumW'(fill_ack)
             - SumW'(spill_ack) - (apply_pop ? SumW'(pop_need) : '0);
    cached_d = cnt_sum[SumW-1] ? '0 : cnt_sum[CntW-1:0];

    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    bottom_d  = bottom_q;
    spilled_d = spilled_q;
    unique case (state_q)
      StIdle: begin
        if (cached_q >= HighW) begin
          state_d = StSpill;
          we_d    = 1'b1;
          addr_d  = stack_base + spilled_q * Stride;
        end else if (cached_q <= LowW && spilled_q != '0) begin
          state_d = StFill;
          we_d    = 1'b0;
          addr_d  = stack_base + (spilled_q - ADDR_WIDTH'(1)) * Stride;
        end
      end
      StSpill: begin
        if (mem_ack) begin
          state_d   = StIdle;
          we_d      = 1'b0;
          bottom_d  = bottom_q + IdxW'(1);
          spilled_d = spilled_q + ADDR_WIDTH'(1);
        end
      end
      StFill: begin
        if (mem_ack) begin
          state_d   = StIdle;
          bottom_d  = bottom_q - IdxW'(1);
          spilled_d = spilled_q - ADDR_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      bottom_q  <= '0;
      cached_q  <= '0;
      spilled_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bottom_q  <= bottom_d;
      cached_q  <= cached_d;
      spilled_q <= spilled_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
    end
  end

  assign mem_req       = (state_q != StIdle);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign fill_we       = fill_ack;
  assign bottom_idx    = bottom_q;
  assign cached_count  = cached_q;
  assign spilled_count = spilled_q;
`ifdef DSTACK_UNDERFLOW_TRAP_EN
  assign underflow     = underrun;
`endif

endmodule
